// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - load/store request/response bus between pipeline MEM stage and data memory
interface data_mem_responder_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic                  resp_valid;
   logic                  resp_ready;
   logic [DATA_WIDTH-1:0] resp_rdata;
   logic                  resp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - multi-cycle handshaked word data memory with error flagging and busy stall
module data_mem_responder #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int DEPTH_LOG2 = 10,
   parameter int LATENCY    = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   data_mem_responder_if.slave  bus,
   output logic                 busy
);
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t                state;
   state_t                state_next;
   logic [3:0]            cnt;
   logic                  cap_we;
   logic [ADDR_WIDTH-1:0] cap_addr;
   logic [DATA_WIDTH-1:0] cap_wdata;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  err_q;
   logic [DATA_WIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];

   logic [DEPTH_LOG2-1:0] index;
   logic                  addr_err;
   logic                  access;

   assign index    = cap_addr[DEPTH_LOG2+1:2];
   assign addr_err = (cap_addr[1:0] != 2'b00) || ((cap_addr >> (DEPTH_LOG2 + 2)) != '0);
   assign access   = (state == S_WAIT) && (cnt == 4'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (bus.req_valid)  state_next = S_WAIT;
         S_WAIT:  if (cnt == 4'd0)    state_next = S_RESP;
         S_RESP:  if (bus.resp_ready) state_next = S_IDLE;
         default:                     state_next = S_IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      busy           = 1'b1;
      case (state)
         S_IDLE: begin
            bus.req_ready = 1'b1;
            busy          = 1'b0;
         end
         S_RESP:  bus.resp_valid = 1'b1;
         default: ;
      endcase
   end

   assign bus.resp_rdata = rdata_q;
   assign bus.resp_err   = err_q;

   // Captured request and response registers; the array itself is never reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= 4'd0;
         cap_we    <= 1'b0;
         cap_addr  <= '0;
         cap_wdata <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.req_valid) begin
                  cap_we    <= bus.req_we;
                  cap_addr  <= bus.req_addr;
                  cap_wdata <= bus.req_wdata;
                  cnt       <= 4'(LATENCY - 1);
               end
            end
            S_WAIT: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  err_q   <= addr_err;
                  rdata_q <= (!addr_err && !cap_we) ? mem[index] : '0;
               end
            end
            S_RESP: begin
               if (bus.resp_ready) begin
                  rdata_q <= '0;
                  err_q   <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // Stores commit only on the access edge, so a reset during WAIT leaves memory untouched.
   always_ff @(posedge clk) begin
      if (access && cap_we && !addr_err) mem[index] <= cap_wdata;
   end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - self-checking bench for data_mem_responder
module tb_data_mem_responder;
   logic clk;
   logic rst;
   logic rst1;
   logic busy0;
   logic busy1;

   int vectors;
   int miscompares;

   data_mem_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus0 ();
   data_mem_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus1 ();

   data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_LOG2(10), .LATENCY(2)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus0.slave),
      .busy (busy0)
   );

   data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_LOG2(10), .LATENCY(1)) dut1 (
      .clk  (clk),
      .rst  (rst1),
      .bus  (bus1.slave),
      .busy (busy1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_err;
      logic [31:0] exp_rdata;
      int          hold;
   } vec_t;

   vec_t        tbl [15];
   logic [31:0] model_mem [0:15];

   task automatic check1(input string name, input logic act, input logic exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s actual=%b expected=%b", name, act, exp);
      end
   endtask

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Starts at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
   task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input int hold, input logic exp_err, input logic [31:0] exp_rdata,
                         input string name);
      int lat;
      bus0.req_valid = 1'b1;
      bus0.req_we    = we;
      bus0.req_addr  = addr;
      bus0.req_wdata = wdata;
      @(posedge clk); #1;
      bus0.req_valid = 1'b0;
      lat = 0;
      @(negedge clk);
      check1({name, "_ready_drop"}, bus0.req_ready, 1'b0);
      while (!bus0.resp_valid && lat < 20) begin
         @(posedge clk); lat++;
         @(negedge clk);
      end
      check32({name, "_latency"}, 32'(lat), 32'd2);
      check1({name, "_err"}, bus0.resp_err, exp_err);
      check32({name, "_rdata"}, bus0.resp_rdata, exp_rdata);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); @(negedge clk);
         check1({name, "_hold_valid"}, bus0.resp_valid, 1'b1);
         check32({name, "_hold_rdata"}, bus0.resp_rdata, exp_rdata);
         check1({name, "_hold_err"}, bus0.resp_err, exp_err);
         check1({name, "_hold_busy"}, busy0, 1'b1);
      end
      bus0.resp_ready = 1'b1;
      @(posedge clk); #1;
      bus0.resp_ready = 1'b0;
      @(negedge clk);
      check1({name, "_idle_ready"}, bus0.req_ready, 1'b1);
      check1({name, "_idle_valid"}, bus0.resp_valid, 1'b0);
      check1({name, "_idle_busy"}, busy0, 1'b0);
      check32({name, "_idle_rdata"}, bus0.resp_rdata, 32'h0);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        we;
      logic        err;
      int          r;
      int          idx;

      vectors = 0;
      miscompares = 0;
      rst  = 1'b1;
      rst1 = 1'b1;
      bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = '0; bus0.req_wdata = '0;
      bus0.resp_ready = 1'b0;
      bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_addr = '0; bus1.req_wdata = '0;
      bus1.resp_ready = 1'b1;

      tbl[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0,          0};
      tbl[1]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF,  0};
      tbl[2]  = '{1'b0, 32'h0000_0012, 32'h0,         1'b1, 32'h0,          0};
      tbl[3]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF,  0};
      tbl[4]  = '{1'b1, 32'h0000_0000, 32'h1111_1111, 1'b0, 32'h0,          0};
      tbl[5]  = '{1'b1, 32'h0000_1000, 32'hCAFE_F00D, 1'b1, 32'h0,          0};
      tbl[6]  = '{1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h1111_1111,  0};
      tbl[7]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF,  5};
      tbl[8]  = '{1'b1, 32'h0000_0FFC, 32'h0BAD_C0DE, 1'b0, 32'h0,          0};
      tbl[9]  = '{1'b0, 32'h0000_0FFC, 32'h0,         1'b0, 32'h0BAD_C0DE,  0};
      tbl[10] = '{1'b0, 32'h8000_0010, 32'h0,         1'b1, 32'h0,          0};
      tbl[11] = '{1'b1, 32'h0000_0020, 32'h0,         1'b0, 32'h0,          0};
      tbl[12] = '{1'b1, 32'h0000_0013, 32'h5555_5555, 1'b1, 32'h0,          0};
      tbl[13] = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF,  0};
      tbl[14] = '{1'b0, 32'h0000_0020, 32'h0,         1'b0, 32'h0,          2};

      repeat (2) @(posedge clk);
      @(negedge clk);
      check1("rst_ready", bus0.req_ready, 1'b1);
      check1("rst_valid", bus0.resp_valid, 1'b0);
      check1("rst_err", bus0.resp_err, 1'b0);
      check32("rst_rdata", bus0.resp_rdata, 32'h0);
      check1("rst_busy", busy0, 1'b0);
      check1("rst1_ready", bus1.req_ready, 1'b1);
      check1("rst1_busy", busy1, 1'b0);
      #1 rst = 1'b0; rst1 = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 15; i++)
         do_txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].hold,
                tbl[i].exp_err, tbl[i].exp_rdata, $sformatf("tbl%0d", i));

      // Asynchronous reset in the middle of WAIT abandons the pending store.
      bus0.req_valid = 1'b1; bus0.req_we = 1'b1;
      bus0.req_addr = 32'h20; bus0.req_wdata = 32'h1234_5678;
      @(posedge clk); #1;
      bus0.req_valid = 1'b0;
      check1("abort_in_wait", busy0, 1'b1);
      #1 rst = 1'b1;
      #1;
      check1("abort_ready", bus0.req_ready, 1'b1);
      check1("abort_busy", busy0, 1'b0);
      check1("abort_valid", bus0.resp_valid, 1'b0);
      check1("abort_err", bus0.resp_err, 1'b0);
      check32("abort_rdata", bus0.resp_rdata, 32'h0);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      do_txn(1'b0, 32'h20, 32'h0, 0, 1'b0, 32'h0, "abort_readback");

      for (int i = 0; i < 16; i++) begin
         model_mem[i] = $urandom;
         do_txn(1'b1, 32'(i * 4), model_mem[i], 0, 1'b0, 32'h0, $sformatf("fill%0d", i));
      end

      for (int n = 0; n < 60; n++) begin
         r     = $urandom_range(0, 7);
         idx   = $urandom_range(0, 15);
         addr  = 32'(idx * 4);
         if (r == 0) addr = addr | 32'($urandom_range(1, 3));
         if (r == 1) addr = ($urandom | 32'h0000_1000) & 32'hFFFF_FFFC;
         we    = 1'($urandom_range(0, 1));
         wdata = $urandom;
         err   = (addr % 4 != 0) || (addr >= 32'h1000);
         do_txn(we, addr, wdata, $urandom_range(0, 2), err,
                (err || we) ? 32'h0 : model_mem[addr / 4], $sformatf("rnd%0d", n));
         if (we && !err) model_mem[addr / 4] = wdata;
      end

      // LATENCY=1 instance: back-to-back store then load with resp_ready tied high.
      for (int t = 0; t < 2; t++) begin
         bus1.req_valid = 1'b1;
         bus1.req_we    = (t == 0);
         bus1.req_addr  = 32'h4;
         bus1.req_wdata = 32'hA5;
         @(negedge clk);
         check1($sformatf("l1_t%0d_c0_ready", t), bus1.req_ready, 1'b1);
         check1($sformatf("l1_t%0d_c0_busy", t), busy1, 1'b0);
         @(posedge clk); #1;
         bus1.req_valid = 1'b0;
         @(negedge clk);
         check1($sformatf("l1_t%0d_c1_ready", t), bus1.req_ready, 1'b0);
         check1($sformatf("l1_t%0d_c1_busy", t), busy1, 1'b1);
         check1($sformatf("l1_t%0d_c1_valid", t), bus1.resp_valid, 1'b0);
         @(posedge clk);
         @(negedge clk);
         check1($sformatf("l1_t%0d_c2_ready", t), bus1.req_ready, 1'b0);
         check1($sformatf("l1_t%0d_c2_busy", t), busy1, 1'b1);
         check1($sformatf("l1_t%0d_c2_valid", t), bus1.resp_valid, 1'b1);
         check1($sformatf("l1_t%0d_c2_err", t), bus1.resp_err, 1'b0);
         check32($sformatf("l1_t%0d_c2_rdata", t), bus1.resp_rdata, (t == 1) ? 32'hA5 : 32'h0);
         @(posedge clk); #1;
      end
      @(negedge clk);
      check1("l1_end_ready", bus1.req_ready, 1'b1);
      check1("l1_end_busy", busy1, 1'b0);
      check1("l1_end_valid", bus1.resp_valid, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the core's MEM-stage data port: the target end of the load/store interface the pipeline drives (address, write data, write enable, read data).
- Replaces the zero-latency combinational data memory with a multi-cycle, handshaked word memory.
- Holds one request at a time, returns read data or a write acknowledge after a fixed latency, and flags misaligned or out-of-range accesses.
- Exports a busy level that the hazard unit uses to stall the pipeline.

Parameters:
- DATA_WIDTH, 32, word width in bits.
- ADDR_WIDTH, 32, byte-address width of the request.
- DEPTH_LOG2, 10, log2 of the number of words; 1024 words by default, covering byte addresses 0x000–0xFFF.
- LATENCY, 2, cycles from request accept to resp_valid; legal range 1..15.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  initiator presents a request.
- req_ready  out  1  responder can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data.
- resp_valid  out  1  response available.
- resp_ready  in  1  initiator consumes the response.
- resp_rdata  out  DATA_WIDTH  load data; 0 for stores and errors.
- resp_err  out  1  misaligned or out-of-range access.
- busy  out  1  high whenever state != IDLE; drives the hazard-unit stall.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values: state=IDLE, latency counter=0, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, busy=0, captured request registers=0.
- Memory array is not cleared by reset.
- State machine: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: capture we/addr/wdata, load counter with LATENCY-1, go to WAIT.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle.
  - When counter==0, perform the access and go to RESP.
  - With LATENCY=1, WAIT lasts exactly one cycle.
- Access performed at the WAIT->RESP edge:
  - Word index = addr[DEPTH_LOG2+1:2].
  - Error if addr[1:0]!=0 or addr[ADDR_WIDTH-1:DEPTH_LOG2+2]!=0.
  - Error: no memory read or write; resp_err=1; resp_rdata=0.
  - Valid load: resp_rdata = mem[index], registered.
  - Valid store: mem[index] <= wdata; resp_rdata=0.
- RESP:
  - resp_valid=1; resp_rdata and resp_err held stable.
  - On resp_ready, go to IDLE and clear resp_valid, resp_rdata and resp_err on that edge.
  - If resp_ready stays low, hold indefinitely with outputs unchanged.
- Latency: accept edge to resp_valid high is exactly LATENCY cycles.
- Throughput: at most one request per LATENCY+2 cycles. A back-to-back request is not accepted in the cycle the response is consumed; req_ready returns on the following cycle.
- Request inputs are ignored while req_ready=0. The initiator holds them until accepted.
- Read-after-write: a store committed before a later load's access edge is always visible to that load. No bypass is needed because requests are strictly serialised.
- Reset mid-operation:
  - A request in WAIT is abandoned; a store not yet committed does not modify memory.
  - A store already committed (state RESP) stays in memory.
- busy = (state != IDLE), combinational from the state register.

Test Plan:
- Reset, then store 0xDEADBEEF to 0x010 with LATENCY=2 -> req_ready drops the cycle after accept; resp_valid rises 2 cycles after accept with resp_err=0 and resp_rdata=0; load from 0x010 -> resp_rdata=0xDEADBEEF.
- Load from 0x012 (misaligned) -> resp_err=1, resp_rdata=0, latency still 2; memory unchanged, confirmed by reading back 0x010.
- Store to 0x1000 (out of range for DEPTH_LOG2=10) -> resp_err=1; word 0 (0x000) is not aliased or overwritten.
- Load with resp_ready held low 5 cycles after resp_valid -> resp_valid, resp_rdata and busy stay stable for all 5 cycles; one cycle after resp_ready=1, state=IDLE and req_ready=1.
- Store 0x12345678 to 0x020; assert rst asynchronously mid-cycle during WAIT -> all outputs reset immediately, without waiting for a clock edge; a subsequent load of 0x020 returns the prior contents (0 if never written).
- LATENCY=1, back-to-back store 0xA5 to 0x004 then load 0x004 with resp_ready tied high -> load returns 0xA5; req_ready pattern is 1,0,0,1 per transaction; busy mirrors ~req_ready.
